// File: rtl/fnd_scan_driver.sv
// Four-digit multiplexed FND scan driver: frame-coherent BCD shadow, anti-ghost blanking,
// leading-zero suppression and blinking colon dot. Define FND_DIM_EN to add the i_dim input.
module fnd_scan_driver #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 2000,
  parameter int unsigned BLINK_DIV = 50000000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_bcd,
  input  logic [3:0]  i_dp_mask,
  input  logic        i_blank_lz,
  input  logic        i_blink_dp,
`ifdef FND_DIM_EN
  input  logic        i_dim,
`endif
  output logic [7:0]  o_font,
  output logic [3:0]  o_digit,
  output logic        o_frame_done
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
`ifdef FND_DIM_EN
  localparam int unsigned DIM_END = BLANK_CYC + (SCAN_DIV - BLANK_CYC) / 4;
`endif

  typedef enum logic {S_BLANK, S_ON} state_t;

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  state_t        state_q, state_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic          pend_q, pend_d;
  logic [7:0]    font_q, font_d;
  logic [3:0]    digit_q, digit_d;
  logic          frame_q;

  logic       slot_end, frame_end, blink_wrap, lit, lz_blank, dp_on;
  logic [3:0] nib, zero;
  logic [7:0] seg;

  always_comb begin
    slot_end    = (presc_q == PW'(SCAN_DIV - 1));
    frame_end   = slot_end && (idx_q == 2'd3);
    presc_d     = slot_end ? '0 : presc_q + 1'b1;
    idx_d       = slot_end ? idx_q + 2'd1 : idx_q;
    shadow_d    = frame_end ? i_bcd : shadow_q;
    pend_d      = frame_end;
    blink_wrap  = (blink_cnt_q == BW'(BLINK_DIV - 1));
    blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    blink_d     = blink_wrap ? ~blink_q : blink_q;

    lit = (presc_q >= PW'(BLANK_CYC));
`ifdef FND_DIM_EN
    if (i_dim && (presc_q >= PW'(DIM_END))) lit = 1'b0;
`endif
    state_d = lit ? S_ON : S_BLANK;

    nib  = shadow_q[{idx_q, 2'b00} +: 4];
    zero = {shadow_q[15:12] == 4'd0, shadow_q[11:8] == 4'd0,
            shadow_q[7:4] == 4'd0,   shadow_q[3:0] == 4'd0};
    // A digit is a leading zero only if every digit to its left is also zero.
    case (idx_q)
      2'd3:    lz_blank = zero[3];
      2'd2:    lz_blank = zero[3] & zero[2];
      2'd1:    lz_blank = zero[3] & zero[2] & zero[1];
      default: lz_blank = 1'b0;
    endcase
    lz_blank = lz_blank & i_blank_lz;

    case (nib)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = 8'hBF;
    endcase

    dp_on   = i_dp_mask[idx_q] && !((idx_q == 2'd2) && i_blink_dp && !blink_q) && !lz_blank;
    font_d  = lz_blank ? 8'hFF : {~dp_on, seg[6:0]};
    digit_d = ~(4'b0001 << idx_q);
    if (state_d == S_BLANK) begin
      font_d  = '1;
      digit_d = '1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      presc_q     <= '0;
      idx_q       <= '0;
      state_q     <= S_BLANK;
      shadow_q    <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
      pend_q      <= 1'b0;
      font_q      <= '1;
      digit_q     <= '1;
      frame_q     <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      pend_q      <= pend_d;
      font_q      <= font_d;
      digit_q     <= digit_d;
      // Delayed one extra clock so the pulse lines up with slot 0's blank on the outputs.
      frame_q     <= pend_q;
    end
  end

  assign o_font       = font_q;
  assign o_digit      = digit_q;
  assign o_frame_done = frame_q;

endmodule
